// File: rtl/pixel_stream_proc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_stream_proc: 2-stage pixel point-op pipeline with frame shadows.   |
// | Optional PIXPROC_STATS_EN adds frame/stall counters at 0x14/0x15.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pixel_stream_proc #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  reg_write_en,
  input  logic [4:0]            reg_addr,
  input  logic [7:0]            reg_wdata,
  output logic [7:0]            reg_rdata
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int PW = DATA_WIDTH + 8;
  localparam int SW = PW + 1;
  localparam logic [DATA_WIDTH-1:0] MAX_VAL = '1;
  localparam logic [4:0] ADDR_MODE   = 5'h00;
  localparam logic [4:0] ADDR_THRESH = 5'h01;
  localparam logic [4:0] ADDR_GAIN   = 5'h02;
  localparam logic [4:0] ADDR_OFFSET = 5'h03;
  localparam logic [4:0] ADDR_STATUS = 5'h10;
  localparam logic [4:0] ADDR_ID     = 5'h11;
  localparam logic [7:0] ID_VALUE    = 8'hA6;
`ifdef PIXPROC_STATS_EN
  localparam logic [4:0] ADDR_FRAMES = 5'h14;
  localparam logic [4:0] ADDR_STALLS = 5'h15;
`endif

  logic [1:0] mode, sh_mode;
  logic [7:0] thresh, gain, offset, sh_thresh, sh_gain, sh_offset;
  logic       frame_done;

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic                  s1_valid, s1_last;
  logic [DATA_WIDTH-1:0] s1_data;

  logic en, in_acc, out_acc, col_end, row_end, first_px, busy;
  logic [PW-1:0]         scaled;
  logic signed [SW-1:0]  off_ext, sum_val;
  logic [DATA_WIDTH-1:0] proc_out;

  assign en       = !m_valid || m_ready;
  assign s_ready  = en;
  assign in_acc   = s_valid && en;
  assign out_acc  = m_valid && m_ready;
  assign col_end  = (col == CW'(IMG_WIDTH - 1));
  assign row_end  = (row == RW'(IMG_HEIGHT - 1));
  assign first_px = (col == '0) && (row == '0);
  assign busy     = s1_valid || m_valid || (col != '0) || (row != '0);

  // Gain is Q4.4; offset is scaled up so it stays aligned to the pixel MSBs.
  assign scaled  = (PW'(s1_data) * PW'(sh_gain)) >> 4;
  assign off_ext = $signed({{(SW-8){sh_offset[7]}}, sh_offset}) <<< (DATA_WIDTH - 8);
  assign sum_val = $signed({1'b0, scaled}) + off_ext;

  always_comb begin
    proc_out = s1_data;
    case (sh_mode)
      2'd0: proc_out = s1_data;
      2'd1: proc_out = MAX_VAL - s1_data;
      2'd2: proc_out = (s1_data[DATA_WIDTH-1 -: 8] >= sh_thresh) ? MAX_VAL : '0;
      default: begin
        if (sum_val[SW-1])
          proc_out = '0;
        else if (|sum_val[SW-2:DATA_WIDTH])
          proc_out = MAX_VAL;
        else
          proc_out = sum_val[DATA_WIDTH-1:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode   <= 2'd0;
      thresh <= 8'h80;
      gain   <= 8'h10;
      offset <= 8'h00;
    end else if (reg_write_en) begin
      case (reg_addr)
        ADDR_MODE:   mode   <= reg_wdata[1:0];
        ADDR_THRESH: thresh <= reg_wdata;
        ADDR_GAIN:   gain   <= reg_wdata;
        ADDR_OFFSET: offset <= reg_wdata;
        default: ;
      endcase
    end
  end

  // Shadows sample the pre-write register values, so a coincident write lands next frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_mode   <= 2'd0;
      sh_thresh <= 8'h80;
      sh_gain   <= 8'h10;
      sh_offset <= 8'h00;
    end else if (in_acc && first_px) begin
      sh_mode   <= mode;
      sh_thresh <= thresh;
      sh_gain   <= gain;
      sh_offset <= offset;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col <= '0;
      row <= '0;
    end else if (in_acc) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_last  <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
    end else if (en) begin
      s1_valid <= s_valid;
      if (in_acc) begin
        s1_data <= s_data;
        s1_last <= col_end && row_end;
      end
      m_valid <= s1_valid;
      m_data  <= proc_out;
      m_last  <= s1_valid && s1_last;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      frame_done <= 1'b0;
    else if (out_acc && m_last)
      frame_done <= 1'b1;
    else if (reg_write_en && (reg_addr == ADDR_STATUS) && reg_wdata[1])
      frame_done <= 1'b0;
  end

`ifdef PIXPROC_STATS_EN
  logic [7:0] frame_cnt, stall_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt <= 8'd0;
      stall_cnt <= 8'd0;
    end else if (reg_write_en && (reg_addr == ADDR_FRAMES)) begin
      frame_cnt <= 8'd0;
      stall_cnt <= 8'd0;
    end else begin
      if (out_acc && m_last)
        frame_cnt <= frame_cnt + 8'd1;
      if (m_valid && !m_ready && (stall_cnt != 8'hFF))
        stall_cnt <= stall_cnt + 8'd1;
    end
  end
`endif

  always_comb begin
    reg_rdata = 8'h00;
    case (reg_addr)
      ADDR_MODE:   reg_rdata = {6'd0, mode};
      ADDR_THRESH: reg_rdata = thresh;
      ADDR_GAIN:   reg_rdata = gain;
      ADDR_OFFSET: reg_rdata = offset;
      ADDR_STATUS: reg_rdata = {6'd0, frame_done, busy};
      ADDR_ID:     reg_rdata = ID_VALUE;
`ifdef PIXPROC_STATS_EN
      ADDR_FRAMES: reg_rdata = frame_cnt;
      ADDR_STALLS: reg_rdata = stall_cnt;
`endif
      default:     reg_rdata = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/pixel_stream_proc.md
PIXEL_STREAM_PROC -- requirements
Module: pixel_stream_proc

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel width; legal range 8..16.
REQ-002 Parameter IMG_WIDTH, default 32, pixels per line; legal range >= 2.
REQ-003 Parameter IMG_HEIGHT, default 32, lines per frame; legal range >= 2.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 s_valid  in  1  input pixel valid.
REQ-007 s_ready  out  1  input pixel accepted when s_valid && s_ready.
REQ-008 s_data  in  DATA_WIDTH  input pixel, raster order.
REQ-009 m_valid  out  1  output pixel valid.
REQ-010 m_ready  in  1  downstream accept.
REQ-011 m_data  out  DATA_WIDTH  processed pixel.
REQ-012 m_last  out  1  high on the last pixel of a frame.
REQ-013 reg_write_en  in  1  register write strobe.
REQ-014 reg_addr  in  5  register address.
REQ-015 reg_wdata  in  8  write data.
REQ-016 reg_rdata  out  8  read data, combinational from reg_addr.

Function
REQ-017 Register map: 0x00 mode[1:0] (reset 0); 0x01 thresh (reset 0x80); 0x02 gain, unsigned Q4.4 (reset 0x10); 0x03 offset, signed 8-bit (reset 0x00); 0x10 status (R, W1C); 0x11 ID = 0xA6 (R); unmapped reads return 0x00, unmapped writes are ignored.
REQ-018 Mode 0: bypass, out = x; mode 1: invert, out = MAX - x, where MAX = 2^DATA_WIDTH-1.
REQ-019 Mode 2: threshold, out = MAX if x[DATA_WIDTH-1 -: 8] >= thresh, else 0.
REQ-020 Mode 3: out = sat((x*gain)>>4 + (offset << (DATA_WIDTH-8))), signed intermediate with no overflow, clamped to 0..MAX.
REQ-021 Two-stage pipeline; both stages advance when en = !m_valid || m_ready; s_ready = en.
REQ-022 Latency is exactly 2 cycles from input acceptance to m_valid with m_ready held high; throughput is 1 pixel/clock.
REQ-023 While m_valid && !m_ready, m_data and m_last hold stable and no input is accepted.
REQ-024 Input column/row counters advance on each accepted beat; column wraps at IMG_WIDTH-1 and increments row; row wraps at IMG_HEIGHT-1 to 0.
REQ-025 The last flag (column = IMG_WIDTH-1 and row = IMG_HEIGHT-1) travels with the pixel through the pipeline and drives m_last.
REQ-026 Shadow copies of mode/thresh/gain/offset are captured on acceptance of the frame's first pixel (column 0, row 0) and apply to that whole frame; register writes mid-frame take effect on the next frame.
REQ-027 A write coinciding with the first-pixel capture is not seen by that frame's shadow.
REQ-028 status[0] busy = any pipeline stage valid or input counters nonzero; status[1] frame_done is sticky, set when an m_last beat is accepted.
REQ-029 Writing 1 to status bit 1 clears it; a simultaneous set wins.

Reset
REQ-030 On rstn low, regardless of state: registers and shadows take their reset values, counters and pipeline valids clear, m_valid=0, m_last=0, m_data=0, s_ready=1 after release.
REQ-031 Reset mid-frame discards in-flight pixels; the next accepted pixel is column 0, row 0.

Configuration
REQ-032 Macro PIXPROC_STATS_EN: when defined, 0x14 is an 8-bit frame counter, incremented on each accepted m_last beat and wrapping 255->0; 0x15 is an 8-bit stall counter, incremented each cycle m_valid && !m_ready and saturating at 255; both are cleared by a write to 0x14.
REQ-033 When PIXPROC_STATS_EN is undefined: no counter logic exists, and 0x14/0x15 read 0x00.

Verification
REQ-034 Mode 1, DATA_WIDTH=8, input 0x00,0x37,0xFF with m_ready=1 -> outputs 0xFF,0xC8,0x00, each 2 cycles after acceptance.
REQ-035 Mode 3, gain=0x20, offset=0x10, inputs 0x10,0x90 -> 0x30, 0xFF (saturated); offset=0xF0, input 0x04 -> 0x00 (clamped low).
REQ-036 Full 32x32 frame with m_ready toggling pseudo-randomly -> 1024 outputs in order, none lost or duplicated, m_last only on the 1024th, status[1]=1, then write 0x02 to 0x10 -> status[1]=0.
REQ-037 Write mode=2 at pixel 500 of a mode-0 frame -> rest of frame bypassed, next frame thresholded against thresh=0x80.
REQ-038 Assert rstn low mid-frame with m_valid=1 -> m_valid=0 immediately, registers at reset values, next frame's m_last after exactly 1024 beats.
REQ-039 With PIXPROC_STATS_EN, 3 frames plus 5 stalled cycles -> 0x14 reads 3, 0x15 reads 5; without it, both read 0x00.
